// File: rtl/fifo_read_stream_adapter.sv
// Read-side FIFO adapter: issues reads against a fixed-latency SRAM FIFO, tracks them
// in flight and re-presents the returned words as a first-word-fall-through stream.
module fifo_read_stream_adapter_chk #(
  parameter int buffer_depth = 5,
  parameter int cnt_w        = 3
) (
  input logic             rclk,
  input logic             reset,
  input logic             fifo_empty,
  input logic             fifo_r,
  input logic [cnt_w-1:0] level
);
  localparam logic [cnt_w-1:0] depth_c = cnt_w'(buffer_depth);

  level_bound_a: assert property (@(posedge rclk) disable iff (reset) level <= depth_c);
  no_read_empty_a: assert property (@(posedge rclk) disable iff (reset) !(fifo_r && fifo_empty));
endmodule

module fifo_read_stream_adapter #(
  parameter int word_size    = 16,
  parameter int read_latency = 3,
  parameter int buffer_depth = 5
) (
  input  logic                              rclk,
  input  logic                              reset,
  input  logic                              fifo_empty,
  output logic                              fifo_r,
  input  logic [word_size-1:0]              fifo_rdata,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [word_size-1:0]              out_data,
  output logic [$clog2(buffer_depth+1)-1:0] level
);
  localparam int cnt_w = $clog2(buffer_depth + 1);
  localparam int ptr_w = $clog2(buffer_depth);
  localparam logic [cnt_w-1:0] depth_c = cnt_w'(buffer_depth);

  if ((read_latency < 1) || (read_latency > 8) || (buffer_depth < read_latency + 1)) begin : g_param_check
    $error("fifo_read_stream_adapter: read_latency must be 1..8 and buffer_depth >= read_latency+1");
  end

  logic [read_latency-1:0] inflight_r;
  logic [read_latency:0]   shift_s;
  logic [cnt_w-1:0]        credit_r;
  logic [cnt_w-1:0]        level_r;
  logic [cnt_w-1:0]        level_next_s;
  logic [ptr_w-1:0]        wptr_r;
  logic [ptr_w-1:0]        rptr_r;
  logic                    valid_r;
  logic [word_size-1:0]    mem_r [buffer_depth];
  logic                    fifo_r_s;
  logic                    capture_s;
  logic                    pop_s;

  function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
    if (p == ptr_w'(buffer_depth - 1)) begin
      return ptr_w'(0);
    end else begin
      return p + ptr_w'(1);
    end
  endfunction

  // Credit covers both in-flight reads and stored words, so a capture never overflows.
  assign fifo_r_s     = !reset && !fifo_empty && (credit_r < depth_c);
  assign shift_s      = {inflight_r, fifo_r_s};
  assign capture_s    = inflight_r[read_latency-1];
  assign pop_s        = valid_r && out_ready;
  assign level_next_s = level_r + cnt_w'(capture_s) - cnt_w'(pop_s);

  // Control state: issue tags, credit, occupancy, pointers and the registered valid.
  always_ff @(posedge rclk) begin
    if (reset) begin
      inflight_r <= {read_latency{1'b0}};
      credit_r   <= cnt_w'(0);
      level_r    <= cnt_w'(0);
      wptr_r     <= ptr_w'(0);
      rptr_r     <= ptr_w'(0);
      valid_r    <= 1'b0;
    end else begin
      inflight_r <= shift_s[read_latency-1:0];
      credit_r   <= credit_r + cnt_w'(fifo_r_s) - cnt_w'(pop_s);
      level_r    <= level_next_s;
      valid_r    <= (level_next_s != cnt_w'(0));
      if (capture_s) begin
        wptr_r <= ptr_inc(wptr_r);
      end
      if (pop_s) begin
        rptr_r <= ptr_inc(rptr_r);
      end
    end
  end

  // Buffer storage is never cleared; stale contents are masked by valid_r.
  always_ff @(posedge rclk) begin
    if (capture_s && !reset) begin
      mem_r[wptr_r] <= fifo_rdata;
    end
  end

  assign fifo_r    = fifo_r_s;
  assign out_valid = valid_r;
  assign out_data  = mem_r[rptr_r];
  assign level     = level_r;

  fifo_read_stream_adapter_chk #(.buffer_depth(buffer_depth), .cnt_w(cnt_w)) u_chk (
    .rclk       (rclk),
    .reset      (reset),
    .fifo_empty (fifo_empty),
    .fifo_r     (fifo_r_s),
    .level      (level_r)
  );
endmodule
